// File: rtl/seq_monitor.sv
// seq_monitor: watches the code stream of the cyclic FSM stage, measures the
// loop period between entries into START_CODE, counts completed loops and
// flags a stream that stays on one code for STUCK_LIM consecutive samples.
module seq_monitor #(
    parameter int W          = 3,
    parameter int START_CODE = 2,
    parameter int STUCK_LIM  = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     code,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] loop_cnt,
    output logic             stuck,
    output logic [1:0]       mon_state
);

    localparam int RL_W = $clog2(STUCK_LIM + 1);
    localparam logic [W-1:0]     START   = W'(START_CODE);
    localparam logic [RL_W-1:0]  RUN_MAX = RL_W'(STUCK_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STUCK = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     prev_code_reg, prev_code_next;
    logic             have_prev_reg, have_prev_next;
    logic [RL_W-1:0]  run_len_reg, run_len_next;
    logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             period_valid_reg, period_valid_next;
    logic [CNT_W-1:0] loop_cnt_reg, loop_cnt_next;
    logic             is_repeat;
    logic             entry;

    // State and counter register; reset wins over any sample on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            prev_code_reg    <= '0;
            have_prev_reg    <= 1'b0;
            run_len_reg      <= '0;
            per_cnt_reg      <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            loop_cnt_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            prev_code_reg    <= prev_code_next;
            have_prev_reg    <= have_prev_next;
            run_len_reg      <= run_len_next;
            per_cnt_reg      <= per_cnt_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            loop_cnt_reg     <= loop_cnt_next;
        end
    end

    // Next-state logic: run tracking, stuck detection, then loop measurement.
    always_comb begin
        state_next        = state_reg;
        prev_code_next    = prev_code_reg;
        have_prev_next    = have_prev_reg;
        run_len_next      = run_len_reg;
        per_cnt_next      = per_cnt_reg;
        period_next       = period_reg;
        period_valid_next = 1'b0;
        loop_cnt_next     = loop_cnt_reg;
        is_repeat         = 1'b0;
        entry             = 1'b0;

        if (in_valid) begin
            prev_code_next = code;
            have_prev_next = 1'b1;
            is_repeat      = have_prev_reg && (code == prev_code_reg);
            entry          = (code == START) && !is_repeat;

            if (!is_repeat)
                run_len_next = RL_W'(1);
            else if (run_len_reg != RUN_MAX)
                run_len_next = run_len_reg + RL_W'(1);

            if (state_reg == STUCK) begin
                // A fresh code releases the block; it is then judged as from
                // IDLE. The fresh code has run_len 1, so it cannot re-stick.
                if (!is_repeat) begin
                    state_next   = IDLE;
                    per_cnt_next = '0;
                    if (entry) begin
                        state_next   = RUN;
                        per_cnt_next = CNT_ONE;
                    end
                end
            end else if (run_len_next == RUN_MAX) begin
                state_next = STUCK;
            end else if (entry) begin
                if (state_reg == RUN) begin
                    period_next       = per_cnt_reg;
                    period_valid_next = 1'b1;
                    if (loop_cnt_reg != CNT_MAX)
                        loop_cnt_next = loop_cnt_reg + CNT_ONE;
                end
                state_next   = RUN;
                per_cnt_next = CNT_ONE;
            end else if (state_reg == RUN) begin
                if (per_cnt_reg != CNT_MAX)
                    per_cnt_next = per_cnt_reg + CNT_ONE;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        period       = period_reg;
        period_valid = period_valid_reg;
        loop_cnt     = loop_cnt_reg;
        stuck        = (state_reg == STUCK);
        mon_state    = state_reg;
    end

endmodule

// File: tb/tb_seq_monitor.sv
// tb_seq_monitor: drives two monitors (CNT_W=8 and CNT_W=4) with the same
// directed and random code streams and compares every output, every cycle,
// against a reference model based on sample indices of loop entries.
`timescale 1ns/1ps
module tb_seq_monitor;

    localparam int LIM   = 4;
    localparam int START = 2;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [2:0] code;

    logic [7:0] period_a, loop_cnt_a;
    logic       period_valid_a, stuck_a;
    logic [1:0] mon_state_a;
    logic [3:0] period_b, loop_cnt_b;
    logic       period_valid_b, stuck_b;
    logic [1:0] mon_state_b;

    int checks   = 0;
    int failures = 0;

    seq_monitor #(.W(3), .START_CODE(2), .STUCK_LIM(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
        .period(period_a), .period_valid(period_valid_a),
        .loop_cnt(loop_cnt_a), .stuck(stuck_a), .mon_state(mon_state_a)
    );

    seq_monitor #(.W(3), .START_CODE(2), .STUCK_LIM(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
        .period(period_b), .period_valid(period_valid_b),
        .loop_cnt(loop_cnt_b), .stuck(stuck_b), .mon_state(mon_state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one slot per instance. Period is the distance in
    // valid samples between two consecutive loop entries, clipped to max.
    int m_max [2] = '{255, 15};
    int m_mode [2];          // 0 idle, 1 looping, 2 stuck
    int m_have_prev, m_prev, m_run, m_idx;
    int m_entry_idx [2];
    int m_period [2];
    int m_pv [2];
    int m_loops [2];

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_have_prev = 0; m_prev = 0; m_run = 0; m_idx = 0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_entry_idx[i] = 0; m_period[i] = 0;
            m_pv[i] = 0; m_loops[i] = 0;
        end
    endtask

    task automatic model_sample(bit v, int c);
        bit rep, ent;
        for (int i = 0; i < 2; i++) m_pv[i] = 0;
        if (!v) return;
        m_idx++;
        rep = m_have_prev && (c == m_prev);
        m_run = rep ? min2(m_run + 1, LIM) : 1;
        ent = (c == START) && !rep;
        m_have_prev = 1;
        m_prev = c;
        for (int i = 0; i < 2; i++) begin
            if (m_mode[i] == 2) begin
                if (!rep) begin
                    m_mode[i] = 0;
                    if (ent) begin m_mode[i] = 1; m_entry_idx[i] = m_idx; end
                end
            end else if (m_run == LIM) begin
                m_mode[i] = 2;
            end else if (ent) begin
                if (m_mode[i] == 1) begin
                    m_period[i] = min2(m_idx - m_entry_idx[i], m_max[i]);
                    m_pv[i] = 1;
                    m_loops[i] = min2(m_loops[i] + 1, m_max[i]);
                end
                m_mode[i] = 1;
                m_entry_idx[i] = m_idx;
            end
        end
    endtask

    task automatic check_val(string tag, int observed, int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One clock: apply inputs, update the model on the edge, compare 1ns later.
    task automatic step(bit v, int c, bit r);
        in_valid = v;
        code     = 3'(c);
        reset    = r;
        @(posedge clk);
        if (r) model_reset(); else model_sample(v, c);
        #1;
        check_val("a_period",   int'(period_a),       m_period[0]);
        check_val("a_pvalid",   int'(period_valid_a), m_pv[0]);
        check_val("a_loops",    int'(loop_cnt_a),     m_loops[0]);
        check_val("a_stuck",    int'(stuck_a),        (m_mode[0] == 2) ? 1 : 0);
        check_val("a_state",    int'(mon_state_a),    m_mode[0]);
        check_val("b_period",   int'(period_b),       m_period[1]);
        check_val("b_pvalid",   int'(period_valid_b), m_pv[1]);
        check_val("b_loops",    int'(loop_cnt_b),     m_loops[1]);
        check_val("b_stuck",    int'(stuck_b),        (m_mode[1] == 2) ? 1 : 0);
        check_val("b_state",    int'(mon_state_b),    m_mode[1]);
        $display("t=%0t rst=%0d v=%0d code=%0d | period=%0d pv=%0d loops=%0d stuck=%0d st=%0d",
                 $time, r, v, c, period_a, period_valid_a, loop_cnt_a, stuck_a, mon_state_a);
    endtask

    int seq2 [11] = '{2, 5, 3, 5, 4, 2, 5, 3, 5, 4, 2};
    int seq4 [6]  = '{2, 2, 2, 2, 5, 2};

    initial begin
        in_valid = 1'b0;
        code     = 3'd0;
        reset    = 1'b1;
        model_reset();
        #2;
        step(0, 0, 1);
        step(0, 0, 1);
        check_val("reset_state", int'(mon_state_a), 0);

        // Held code: stuck on the fourth sample.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            if (i == 2) check_val("t1_not_yet", int'(stuck_a), 0);
            if (i == 3) check_val("t1_stuck", int'(mon_state_a), 2);
        end
        check_val("t1_loops", int'(loop_cnt_a), 0);

        // Two loops of five samples.
        step(0, 0, 1);
        for (int i = 0; i < 11; i++) step(1, seq2[i], 0);
        check_val("t2_period", int'(period_a), 5);
        check_val("t2_loops",  int'(loop_cnt_a), 2);

        // Same with gaps; a gap must not extend a pulse.
        step(0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            step(1, seq2[i], 0);
            for (int g = 0; g < 3; g++) step(0, 7, 0);
        end
        check_val("t3_period", int'(period_a), 5);
        check_val("t3_loops",  int'(loop_cnt_a), 2);

        // Stuck on START_CODE, release, re-entry without a pulse.
        step(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, seq4[i], 0);
            if (i == 3) check_val("t4_stuck_rise", int'(stuck_a), 1);
            if (i == 4) check_val("t4_stuck_fall", int'(mon_state_a), 0);
        end
        check_val("t4_run",    int'(mon_state_a), 1);
        check_val("t4_nopulse", int'(period_valid_a), 0);

        // Period counter saturation in the narrow instance.
        step(0, 0, 1);
        step(1, 2, 0);
        for (int i = 0; i < 20; i++) step(1, (i % 2 == 0) ? 3 : 4, 0);
        step(1, 2, 0);
        check_val("t5_period_sat", int'(period_b), 15);
        check_val("t5_period_wide", int'(period_a), 21);
        check_val("t5_loops", int'(loop_cnt_b), 1);

        // Reset mid-loop overrides a valid START_CODE sample.
        step(1, 5, 0);
        step(1, 3, 0);
        step(1, 2, 1);
        check_val("t6_state", int'(mon_state_a), 0);
        check_val("t6_loops", int'(loop_cnt_a), 0);
        step(1, 2, 0);
        check_val("t6_nopulse", int'(period_valid_a), 0);

        // Random stream: repeats are frequent so stuck episodes occur.
        for (int n = 0; n < 500; n++) begin
            int c;
            bit v, r;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 3) c = m_prev;
            else if ($urandom_range(0, 4) == 0) c = START;
            else c = $urandom_range(0, 7);
            step(v, c, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
